// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-through, no-write-allocate data cache
// with one 32-bit word per line.
//
// Ports
//   clk, rst             : clock (rising edge) and asynchronous active-low reset
//   ram_en               : core access valid this cycle
//   ram_read_en          : core load request
//   ram_write_en         : core store request (wins over ram_read_en)
//   ram_addr             : core byte address; bits [1:0] are ignored
//   ram_select           : store byte enables; bit i covers data[8i+7:8i]
//   ram_write_data       : store data
//   ram_read_data        : load data; valid when is_cache_hit=1 on a load
//   is_cache_hit         : access complete this cycle; 0 means the core stalls
//                          and holds its request stable
//   mem_req/we/addr/
//   mem_select/mem_wdata : backing-memory request, held until mem_ack
//   mem_ack, mem_rdata   : one-cycle completion strobe and read data
//
// The backing-memory request is decoded from the FSM state and the held core
// request. The core keeps its request stable while stalled, so the mem_*
// fields stay stable until the ack, and they all fall to zero as soon as the
// state is forced to IDLE by reset.
module dcache_direct #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_en,
    input  logic        ram_read_en,
    input  logic        ram_write_en,
    input  logic [31:0] ram_addr,
    input  logic [3:0]  ram_select,
    input  logic [31:0] ram_write_data,
    output logic [31:0] ram_read_data,
    output logic        is_cache_hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_select,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_MISS = 2'd1;
    localparam logic [1:0] WR_THRU = 2'd2;
    localparam logic [1:0] WR_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             line_hit;
    logic             is_store;
    logic             is_load;
    logic             fill;
    logic             merge;
    logic             unused_addr_bits;

    assign idx              = ram_addr[2 +: IDX_W];
    assign tag              = ram_addr[31 -: TAG_W];
    assign unused_addr_bits = ^ram_addr[1:0];
    assign line_hit         = valid[idx] && (tag_mem[idx] == tag);

    // A simultaneous load and store request is handled as a store.
    assign is_store = ram_en && ram_write_en;
    assign is_load  = ram_en && ram_read_en && !ram_write_en;

    // Line updates happen only on the edge that samples mem_ack while a
    // transaction is actually outstanding; a stray ack in IDLE/WR_DONE is ignored.
    assign fill  = (state == RD_MISS) && mem_ack;
    assign merge = (state == WR_THRU) && mem_ack && line_hit;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and infers a latch.
        state_nxt     = state;
        is_cache_hit  = 1'b0;
        ram_read_data = 32'h0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 32'h0;
        mem_select    = 4'h0;
        mem_wdata     = 32'h0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    state_nxt = WR_THRU;
                end else if (is_load) begin
                    if (line_hit) begin
                        is_cache_hit  = 1'b1;
                        ram_read_data = data_mem[idx];
                    end else begin
                        state_nxt = RD_MISS;
                    end
                end else begin
                    is_cache_hit = 1'b1;
                end
            end
            RD_MISS: begin
                mem_req    = 1'b1;
                mem_addr   = {ram_addr[31:2], 2'b00};
                mem_select = 4'hF;
                if (mem_ack) state_nxt = IDLE;
            end
            WR_THRU: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {ram_addr[31:2], 2'b00};
                mem_select = ram_select;
                mem_wdata  = ram_write_data;
                if (mem_ack) state_nxt = WR_DONE;
            end
            default: begin
                // WR_DONE: completion cycle for the store, never re-issued.
                is_cache_hit = 1'b1;
                state_nxt    = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            valid <= '0;
        end else begin
            state <= state_nxt;
            if (fill) valid[idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; a line is only
    // ever read after its valid bit is set by a fill, which also writes them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_rdata;
        end else if (merge) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_select[i]) data_mem[idx][8*i +: 8] <= ram_write_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct (LINES=16). The bench plays both the
// core and the backing memory. A reference model of the cache contents
// (per-index valid/tag/word) predicts hits, load data and byte merges.
module tb_dcache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en;
    logic        ram_read_en;
    logic        ram_write_en;
    logic [31:0] ram_addr;
    logic [3:0]  ram_select;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;
    logic        is_cache_hit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_select;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one entry per index.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];

    dcache_direct #(.LINES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_en         (ram_en),
        .ram_read_en    (ram_read_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_select     (ram_select),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .is_cache_hit   (is_cache_hit),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_select     (mem_select),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
    endfunction

    // One cycle with no load/store; a stray mem_ack may be presented and must be ignored.
    // Tasks start exactly on a falling edge.
    task automatic idle_cycle(input logic en, input logic stray_ack);
        ram_en       = en;
        ram_read_en  = 1'b0;
        ram_write_en = 1'b0;
        ram_addr     = $urandom;
        mem_ack      = stray_ack;
        mem_rdata    = $urandom;
        #1;
        check("idle_hit", {31'h0, is_cache_hit}, 32'h1);
        check("idle_rdata", ram_read_data, 32'h0);
        check("idle_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    // Full core access: drives the request, services the memory side with
    // 'lat' wait cycles before the ack, and checks every cycle against the model.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          input int lat, input logic [31:0] rdata);
        logic [3:0]  ix;
        logic [25:0] tg;
        bit          hit;
        ram_en         = 1'b1;
        ram_read_en    = rd;
        ram_write_en   = wr;
        ram_addr       = addr;
        ram_select     = sel;
        ram_write_data = wd;
        mem_ack        = 1'b0;
        ix  = addr[5:2];
        tg  = addr[31:6];
        hit = m_valid[ix] && (m_tag[ix] == tg);
        #1;
        if (!rd && !wr) begin
            check("nop_hit", {31'h0, is_cache_hit}, 32'h1);
            check("nop_rdata", ram_read_data, 32'h0);
            check("nop_req", {31'h0, mem_req}, 32'h0);
            @(negedge clk);
            return;
        end
        if (!wr && hit) begin
            check("ld_hit", {31'h0, is_cache_hit}, 32'h1);
            check("ld_hit_data", ram_read_data, m_data[ix]);
            check("ld_hit_req", {31'h0, mem_req}, 32'h0);
            @(negedge clk);
            return;
        end
        check("first_stall", {31'h0, is_cache_hit}, 32'h0);
        check("first_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        #1;
        for (int c = 0; c <= lat; c++) begin
            check("req", {31'h0, mem_req}, 32'h1);
            check("req_we", {31'h0, mem_we}, {31'h0, wr});
            check("req_addr", mem_addr, {addr[31:2], 2'b00});
            check("req_sel", {28'h0, mem_select}, wr ? {28'h0, sel} : 32'hF);
            if (wr) check("req_wdata", mem_wdata, wd);
            check("req_stall", {31'h0, is_cache_hit}, 32'h0);
            if (c == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_rdata = $urandom;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
        end
        if (wr) begin
            check("st_done_hit", {31'h0, is_cache_hit}, 32'h1);
            check("st_done_req", {31'h0, mem_req}, 32'h0);
            if (hit) begin
                for (int i = 0; i < 4; i++)
                    if (sel[i]) m_data[ix][8*i +: 8] = wd[8*i +: 8];
            end
        end else begin
            m_valid[ix] = 1;
            m_tag[ix]   = tg;
            m_data[ix]  = rdata;
            check("fill_hit", {31'h0, is_cache_hit}, 32'h1);
            check("fill_data", ram_read_data, rdata);
            check("fill_req", {31'h0, mem_req}, 32'h0);
        end
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b0;
        ram_en         = 1'b0;
        ram_read_en    = 1'b0;
        ram_write_en   = 1'b0;
        ram_addr       = 32'h0;
        ram_select     = 4'h0;
        ram_write_data = 32'h0;
        mem_ack        = 1'b0;
        mem_rdata      = 32'h0;
        model_clear();

        // Reset state, before any clock edge.
        #2;
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_sel", {28'h0, mem_select}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_idle_hit", {31'h0, is_cache_hit}, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Load miss, fill, then zero-stall hit.
        access(1, 0, 32'h0000_0040, 4'h0, 32'h0, 2, 32'hDEAD_BEEF);
        access(1, 0, 32'h0000_0040, 4'h0, 32'h0, 0, 32'h0);
        check("dir_fill_word", m_data[0], 32'hDEAD_BEEF);

        // Store hit merging the low two bytes.
        access(0, 1, 32'h0000_0040, 4'b0011, 32'h1234_5678, 1, 32'h0);
        access(1, 0, 32'h0000_0042, 4'h0, 32'h0, 0, 32'h0);
        check("dir_merge_word", m_data[0], 32'hDEAD_5678);

        // Store miss does not allocate; the following load misses and fills.
        access(0, 1, 32'h0000_0080, 4'hF, 32'hAAAA_5555, 0, 32'h0);
        access(1, 0, 32'h0000_0080, 4'h0, 32'h0, 1, 32'hCAFE_0080);
        // Same index, other tag: 0x40 was evicted by the 0x80 fill.
        access(1, 0, 32'h0000_0040, 4'h0, 32'h0, 0, 32'h0BAD_0040);
        access(1, 0, 32'h0000_0080, 4'h0, 32'h0, 3, 32'h1111_2222);

        // Idle cycles: ram_en=0 and ram_en=1 with no enables, stray acks ignored.
        idle_cycle(1'b0, 1'b1);
        idle_cycle(1'b1, 1'b1);
        access(0, 0, 32'h0000_0040, 4'hF, 32'hFFFF_FFFF, 0, 32'h0);

        // Reset in the middle of a read miss abandons it.
        ram_en       = 1'b1;
        ram_read_en  = 1'b1;
        ram_write_en = 1'b0;
        ram_addr     = 32'h0000_01C0;
        #1;
        check("mid_miss", {31'h0, is_cache_hit}, 32'h0);
        @(negedge clk);
        #1;
        check("mid_req_up", {31'h0, mem_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_req", {31'h0, mem_req}, 32'h0);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_sel", {28'h0, mem_select}, 32'h0);
        ram_en = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5151_5151;
        check("late_ack_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        mem_ack = 1'b0;
        access(1, 0, 32'h0000_01C0, 4'h0, 32'h0, 1, 32'h0000_01C0);
        access(1, 0, 32'h0000_0080, 4'h0, 32'h0, 0, 32'h0000_0080);

        // Randomized traffic over a small tag pool so hits, evictions and merges recur.
        for (int n = 0; n < 400; n++) begin
            int          op;
            logic [25:0] tg;
            logic [31:0] a;
            op = $urandom_range(0, 99);
            case ($urandom_range(0, 4))
                0: tg = 26'h0;
                1: tg = 26'h1;
                2: tg = 26'h2;
                3: tg = 26'h3;
                default: tg = 26'h3FF_FFFF;
            endcase
            a = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (op < 45)
                access(1, 0, a, 4'($urandom), $urandom, $urandom_range(0, 3), $urandom);
            else if (op < 80)
                access(1'($urandom), 1, a, 4'($urandom), $urandom, $urandom_range(0, 3), $urandom);
            else if (op < 90)
                access(0, 0, a, 4'($urandom), $urandom, 0, 32'h0);
            else
                idle_cycle(1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_direct.md
DCACHE_DIRECT -- requirements
Module: dcache_direct

Interface
REQ-001 The block SHALL have parameter LINES, default 16, giving the number of one-word direct-mapped lines (power of two, 2..256).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port ram_en  input  1  core data access valid this cycle.
REQ-005 The block SHALL have port ram_read_en  input  1  core load request.
REQ-006 The block SHALL have port ram_write_en  input  1  core store request.
REQ-007 The block SHALL have port ram_addr  input  32  core byte address.
REQ-008 The block SHALL have port ram_select  input  4  store byte enables; bit i covers data[8i+7:8i].
REQ-009 The block SHALL have port ram_write_data  input  32  store data.
REQ-010 The block SHALL have port ram_read_data  output  32  load data.
REQ-011 The block SHALL have port is_cache_hit  output  1  access complete this cycle; 0 = core stalls and holds its request stable.
REQ-012 The block SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_select (out, 4) and mem_wdata (out, 32), forming the backing-memory request.
REQ-013 The block SHALL have ports mem_ack (in, 1), one-cycle completion strobe, and mem_rdata (in, 32), read data valid with mem_ack.

Function
REQ-014 Address split SHALL be: index = ram_addr[2+log2(LINES)-1:2], tag = ram_addr[31:2+log2(LINES)], ram_addr[1:0] ignored; each line holds valid, tag and 32-bit data.
REQ-015 FSM states SHALL be IDLE, RD_MISS, WR_THRU, WR_DONE.
REQ-016 In IDLE with ram_en=0, or with ram_en=1 and both enables 0: is_cache_hit=1, ram_read_data=0, no state change.
REQ-017 When ram_write_en=1 and ram_read_en=1 together, the access SHALL be treated as a store.
REQ-018 IDLE read hit (valid and tag match): is_cache_hit=1 and ram_read_data=line data, combinationally in the same cycle; zero stall.
REQ-019 IDLE read miss: is_cache_hit=0; next state RD_MISS.
REQ-020 In RD_MISS: mem_req=1, mem_we=0, mem_addr={ram_addr[31:2],2'b00}, mem_select=4'hF; is_cache_hit=0; on mem_ack, line is written (data=mem_rdata, tag, valid=1) and state returns to IDLE, where the held request hits the next cycle.
REQ-021 Any IDLE store (hit or miss): is_cache_hit=0; next state WR_THRU.
REQ-022 In WR_THRU: mem_req=1, mem_we=1, mem_addr word-aligned, mem_select=ram_select, mem_wdata=ram_write_data; is_cache_hit=0; on mem_ack go to WR_DONE.
REQ-023 On the WR_THRU ack edge, a store hit SHALL merge only selected bytes into the line; a store miss SHALL NOT allocate or alter any line.
REQ-024 WR_DONE SHALL last exactly one cycle with is_cache_hit=1 and mem_req=0, then go to IDLE; the request is not re-issued.
REQ-025 mem_req and all mem_* request fields SHALL be held stable from assertion until the cycle mem_ack is sampled high; mem_req SHALL drop in the cycle after ack.
REQ-026 mem_ack while mem_req=0 SHALL be ignored.
REQ-027 Latency: read miss SHALL assert mem_req in the cycle after the miss is seen and SHALL hit one cycle after mem_ack; a store SHALL complete (is_cache_hit=1) one cycle after mem_ack.
REQ-028 Index wrap: addresses differing only in tag SHALL evict each other on read fill; the most recent fill wins.

Reset
REQ-029 While rst=0, regardless of clk: state=IDLE, all valid bits=0, mem_req=0, mem_we=0, mem_addr=0, mem_select=0, mem_wdata=0; is_cache_hit and ram_read_data then follow REQ-016/REQ-019.
REQ-030 Reset asserted mid-transaction SHALL abandon it immediately (mem_req low asynchronously); no line is updated from a pending ack.
REQ-031 Tag/data storage need not be reset; only valid bits are.

Verification
REQ-032 After reset, load 0x0000_0040 -> is_cache_hit=0, mem_req next cycle with mem_addr=0x40, mem_select=F; ack with rdata 0xDEADBEEF -> hit next cycle, ram_read_data=0xDEADBEEF; repeat load hits with zero stall and no mem_req.
REQ-033 Store 0x0000_0040, select 4'b0011, data 0x1234_5678, after REQ-032 fill -> mem_we=1, mem_wdata=0x12345678; after ack and WR_DONE, load 0x40 hits with 0xDEAD5678.
REQ-034 Store miss to 0x0000_0080 -> write-through issued; a subsequent load of 0x80 misses (no allocate).
REQ-035 Load 0x40 then load 0x80 (LINES=16, same index 0) each filled -> load 0x40 misses again (eviction).
REQ-036 Assert rst=0 during RD_MISS before ack -> mem_req falls asynchronously; later ack ignored; next load of same address misses.
REQ-037 ram_en=1 with ram_read_en=ram_write_en=0, and ram_en=0 -> is_cache_hit=1, ram_read_data=0, mem_req stays 0.
